// File: rtl/alu_arb_pkg.sv
// Shared constants and the round-robin pick helper for the ALU issue arbiter.
package alu_arb_pkg;

  localparam int BUNDLE_W = 143;
  localparam int RES_W    = 74;
  localparam int MAX_REQ  = 4;

  // Operand bundle field offsets, MSB first
  localparam int FN_LSB   = 139;
  localparam int OP1_LSB  = 107;
  localparam int OP2_LSB  = 75;
  localparam int OP3_LSB  = 43;
  localparam int IMM_LSB  = 11;
  localparam int INST_LSB = 8;
  localparam int F3_LSB   = 5;
  localparam int MEM_LSB  = 3;
  localparam int MISA_BIT = 2;
  localparam int LPC_LSB  = 0;

  // One-hot grant of the first eligible index at or above ptr, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [1:0] ptr,
                                                 input logic [MAX_REQ-1:0] elig,
                                                 input int n);
    logic [MAX_REQ-1:0] grant;
    logic               found;
    int                 idx;
    grant = 4'b0000;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = (int'(ptr) + k) % n;
      if ((k < n) && !found && elig[idx[1:0]]) begin
        grant[idx[1:0]] = 1'b1;
        found           = 1'b1;
      end else begin
        found = found;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/alu_issue_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus its binary index.
module rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     elig,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [MAX_REQ-1:0] elig_w_s;
  logic [MAX_REQ-1:0] grant_w_s;
  logic [1:0]         ptr_w_s;

  // Widen to the helper's fixed width, pick, then encode the winner.
  always_comb begin
    elig_w_s           = 4'b0000;
    elig_w_s[N-1:0]    = elig;
    ptr_w_s            = 2'b00;
    ptr_w_s[IDX_W-1:0] = ptr;
    grant_w_s          = rr_pick(ptr_w_s, elig_w_s, N);
    grant              = grant_w_s[N-1:0];
    grant_idx          = {IDX_W{1'b0}};
    for (int i = 0; i < MAX_REQ; i++) begin
      grant_idx = grant_w_s[i] ? IDX_W'(i) : grant_idx;
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one 1-cycle-latency ALU between NREQ requesters; round-robin issue,
// single in-flight tracking and per-requester response buffers.
module alu_issue_arbiter #(
  parameter int NREQ     = 2,
  parameter int BUNDLE_W = alu_arb_pkg::BUNDLE_W,
  parameter int RES_W    = alu_arb_pkg::RES_W,
  parameter int CNT_W    = 16
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*BUNDLE_W-1:0] req_bundle,
  output logic [NREQ-1:0]          req_ready,
  output logic [NREQ-1:0]          resp_valid,
  output logic [NREQ*RES_W-1:0]    resp_data,
  input  logic [NREQ-1:0]          resp_ready,
  input  logic                     flush,
  output logic                     alu_en,
  output logic [BUNDLE_W-1:0]      alu_bundle,
  input  logic [RES_W-1:0]         alu_result,
  input  logic                     alu_rdy,
  output logic                     err_lost,
  output logic [CNT_W-1:0]         issue_cnt
);
  import alu_arb_pkg::*;

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]  pend_r, rbuf_full_r;
  logic [NREQ-1:0]  pend_nxt_s, rbuf_full_nxt_s;
  logic [NREQ-1:0]  elig_s, grant_s;
  logic [IDX_W-1:0] grant_idx_s, rr_ptr_r, rr_ptr_nxt_s, infl_tag_r;
  logic             infl_valid_r, err_lost_r, issue_s, retire_wr_s;
  logic [RES_W-1:0] rbuf_data_r [NREQ];
  logic [CNT_W-1:0] issue_cnt_r;

  // Eligibility from registered state only; nothing is granted in reset or flush.
  always_comb begin
    if (!RST_N || flush) begin
      elig_s = {NREQ{1'b0}};
    end else begin
      elig_s = req_valid & ~pend_r & ~rbuf_full_r;
    end
  end

  rr_arbiter #(.N(NREQ), .IDX_W(IDX_W)) u_rr (
    .elig      (elig_s),
    .ptr       (rr_ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s)
  );

  assign req_ready = grant_s;
  assign issue_s   = |grant_s;
  assign alu_en    = issue_s;

  // Steer the granted bundle to the ALU, zero when idle.
  always_comb begin
    if (issue_s) begin
      alu_bundle = req_bundle[grant_idx_s*BUNDLE_W +: BUNDLE_W];
    end else begin
      alu_bundle = {BUNDLE_W{1'b0}};
    end
  end

  // A flush in the retire cycle discards the result, so it is never written.
  assign retire_wr_s = infl_valid_r && alu_rdy && !flush;

  // Next pend/buffer-full vectors and pointer after this cycle's events.
  always_comb begin
    pend_nxt_s      = pend_r;
    rbuf_full_nxt_s = rbuf_full_r & ~resp_ready;
    rr_ptr_nxt_s    = rr_ptr_r;
    if (infl_valid_r) begin
      pend_nxt_s[infl_tag_r] = 1'b0;
    end else begin
      pend_nxt_s = pend_nxt_s;
    end
    if (retire_wr_s) begin
      rbuf_full_nxt_s[infl_tag_r] = 1'b1;
    end else begin
      rbuf_full_nxt_s = rbuf_full_nxt_s;
    end
    if (flush) begin
      rbuf_full_nxt_s = {NREQ{1'b0}};
    end else begin
      rbuf_full_nxt_s = rbuf_full_nxt_s;
    end
    if (issue_s) begin
      pend_nxt_s   = pend_nxt_s | grant_s;
      rr_ptr_nxt_s = (grant_idx_s == IDX_W'(NREQ - 1)) ? {IDX_W{1'b0}} : grant_idx_s + IDX_W'(1);
    end else begin
      rr_ptr_nxt_s = rr_ptr_r;
    end
  end

  // Control state: pointer, pend, buffer flags, in-flight tag, error and counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_ptr_r     <= {IDX_W{1'b0}};
      pend_r       <= {NREQ{1'b0}};
      rbuf_full_r  <= {NREQ{1'b0}};
      infl_valid_r <= 1'b0;
      infl_tag_r   <= {IDX_W{1'b0}};
      err_lost_r   <= 1'b0;
      issue_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      rr_ptr_r     <= rr_ptr_nxt_s;
      pend_r       <= pend_nxt_s;
      rbuf_full_r  <= rbuf_full_nxt_s;
      infl_valid_r <= issue_s;
      infl_tag_r   <= issue_s ? grant_idx_s : infl_tag_r;
      err_lost_r   <= err_lost_r | (infl_valid_r && !alu_rdy);
      issue_cnt_r  <= issue_s ? issue_cnt_r + CNT_W'(1) : issue_cnt_r;
    end
  end

  // Response buffer payloads, captured when their requester's result retires.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREQ; i++) begin
        rbuf_data_r[i] <= {RES_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (retire_wr_s && (infl_tag_r == IDX_W'(i))) begin
          rbuf_data_r[i] <= alu_result;
        end else begin
          rbuf_data_r[i] <= rbuf_data_r[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_resp
    assign resp_data[g*RES_W +: RES_W] = rbuf_data_r[g];
  end

  assign resp_valid = rbuf_full_r;
  assign err_lost   = err_lost_r;
  assign issue_cnt  = issue_cnt_r;

endmodule
